// File: rtl/chip_test_pkg.sv
// chip_test_pkg: shared types and constants for the chip test host sequencer.
//   ctl_state_t   - controller state encoding, also shown on the debug hex display
//   DONE_QUALIFY  - consecutive Done cycles needed before the verdict is taken
//   cnt_width     - width of the watchdog / hold counters
package chip_test_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        WAIT_DONE = 3'd2,
        CAPTURE   = 3'd3,
        TIMEOUT   = 3'd4,
        SHOW      = 3'd5,
        RELEASE   = 3'd6
    } ctl_state_t;

    localparam int DONE_QUALIFY = 2;

    // $clog2(max(timeout_cycles, hold_cycles, 2))
    function automatic int cnt_width(input int timeout_cycles, input int hold_cycles);
        int m;
        m = 2;
        if (timeout_cycles > m) m = timeout_cycles;
        if (hold_cycles > m)    m = hold_cycles;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/edge_rise_det.sv
// edge_rise_det: 1-bit rising-edge detector for a debounced button level.
//   Clk    in  system clock
//   Reset  in  synchronous, active-high; preloads the history with the live level
//   level  in  debounced level
//   rise   out level & ~previous level, forced low while Reset is high
module edge_rise_det (
    input  logic Clk,
    input  logic Reset,
    input  logic level,
    output logic rise
);

    logic level_prev;

    // The history register always follows the level, in reset too, so a
    // button already held when Reset drops is seen as old and never fires.
    always_ff @(posedge Clk) begin
        level_prev <= level;
    end

    assign rise = ~Reset & level & ~level_prev;

endmodule

// File: rtl/chip_test_controller.sv
// chip_test_controller: host-side sequencer for the chip checkers.
// Issues a one-cycle Run pulse on a Start press, waits (watchdog-guarded) for
// a qualified Done, latches the verdict on LEDs, and on Ack or hold expiry
// pulses DISP_RSLT so the checker returns to Halted. Keeps saturating tallies.
//   Clk, Reset          clock, synchronous active-high reset
//   Start, Ack          debounced button levels; rising edges are requests
//   Done_i, RSLT_i      checker handshake inputs (RSLT 1 = pass)
//   Run_o, DISP_RSLT_o  one-cycle pulses to the checker
//   Busy                not IDLE
//   Pass_LED, Fail_LED, Timeout_LED   verdict display
//   PassCount, FailCount              saturating tallies
//   State_o             current state encoding
//
// state     | meaning
// IDLE      | waiting for a Start edge; previous verdict LEDs stay lit
// ARM       | Run_o pulse, watchdog cleared
// WAIT_DONE | counting watchdog, qualifying Done
// CAPTURE   | latch RSLT_i, bump pass or fail tally
// TIMEOUT   | no Done in time: fail + timeout LEDs, bump fail tally
// SHOW      | hold verdict until Ack edge or hold expiry
// RELEASE   | DISP_RSLT_o pulse back to the checker
module chip_test_controller
    import chip_test_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int HOLD_CYCLES    = 0,
    parameter int CNT_W          = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack,
    input  logic             Done_i,
    input  logic             RSLT_i,
    output logic             Run_o,
    output logic             DISP_RSLT_o,
    output logic             Busy,
    output logic             Pass_LED,
    output logic             Fail_LED,
    output logic             Timeout_LED,
    output logic [CNT_W-1:0] PassCount,
    output logic [CNT_W-1:0] FailCount,
    output logic [2:0]       State_o
);

    localparam int            CW        = cnt_width(TIMEOUT_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] WD_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = (HOLD_CYCLES == 0) ? '0 : CW'(HOLD_CYCLES - 1);
    localparam logic [1:0]    QUAL_LAST = 2'(DONE_QUALIFY - 1);

    ctl_state_t    state, state_nxt;
    logic [CW-1:0] wd_cnt;
    logic [CW-1:0] hold_cnt;
    logic [1:0]    done_run;
    logic          start_edge, ack_edge;
    logic          done_qual, hold_expired;

    edge_rise_det u_start_det (
        .Clk   (Clk),
        .Reset (Reset),
        .level (Start),
        .rise  (start_edge)
    );

    edge_rise_det u_ack_det (
        .Clk   (Clk),
        .Reset (Reset),
        .level (Ack),
        .rise  (ack_edge)
    );

    // Checker Done is combinational in its last test cycle and RSLT settles a
    // cycle later, so Done must be seen on consecutive cycles before we trust it.
    assign done_qual    = Done_i && (done_run == QUAL_LAST);
    assign hold_expired = (HOLD_CYCLES != 0) && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nxt   = state;
        Run_o       = 1'b0;
        DISP_RSLT_o = 1'b0;
        case (state)
            IDLE:      if (start_edge) state_nxt = ARM;
            ARM: begin
                Run_o     = 1'b1;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A Done qualifying in the last watchdog cycle still wins.
                if (done_qual)             state_nxt = CAPTURE;
                else if (wd_cnt == WD_LAST) state_nxt = TIMEOUT;
            end
            CAPTURE:   state_nxt = SHOW;
            TIMEOUT:   state_nxt = SHOW;
            SHOW:      if (ack_edge || hold_expired) state_nxt = RELEASE;
            RELEASE: begin
                DISP_RSLT_o = 1'b1;
                state_nxt   = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            wd_cnt      <= '0;
            hold_cnt    <= '0;
            done_run    <= '0;
            Pass_LED    <= 1'b0;
            Fail_LED    <= 1'b0;
            Timeout_LED <= 1'b0;
            PassCount   <= '0;
            FailCount   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        Pass_LED    <= 1'b0;
                        Fail_LED    <= 1'b0;
                        Timeout_LED <= 1'b0;
                    end
                end
                ARM: begin
                    wd_cnt   <= '0;
                    done_run <= '0;
                end
                WAIT_DONE: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (!Done_i)                done_run <= '0;
                    else if (done_run != QUAL_LAST) done_run <= done_run + 1'b1;
                end
                CAPTURE: begin
                    hold_cnt <= '0;
                    Pass_LED <= RSLT_i;
                    Fail_LED <= ~RSLT_i;
                    if (RSLT_i) begin
                        if (PassCount != '1) PassCount <= PassCount + 1'b1;
                    end else begin
                        if (FailCount != '1) FailCount <= FailCount + 1'b1;
                    end
                end
                TIMEOUT: begin
                    hold_cnt    <= '0;
                    Timeout_LED <= 1'b1;
                    Fail_LED    <= 1'b1;
                    if (FailCount != '1) FailCount <= FailCount + 1'b1;
                end
                SHOW:    hold_cnt <= hold_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign Busy    = (state != IDLE);
    assign State_o = state;

endmodule

// File: tb/tb_chip_test_controller.sv
// tb_chip_test_controller: directed bench for chip_test_controller.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_chip_test_controller;

    localparam int S_IDLE = 0, S_ARM = 1, S_WAIT = 2, S_CAPT = 3, S_TMO = 4, S_SHOW = 5, S_REL = 6;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic Start = 1'b0, Ack = 1'b0, Done_i = 1'b0, RSLT_i = 1'b0;
    logic Run_o, DISP_RSLT_o, Busy, Pass_LED, Fail_LED, Timeout_LED;
    logic [7:0] PassCount, FailCount;
    logic [2:0] State_o;

    logic h_Start = 1'b0, h_Ack = 1'b0, h_Done = 1'b0, h_RSLT = 1'b0;
    logic h_Run, h_DISP, h_Busy, h_Pass, h_Fail, h_Tmo;
    logic [7:0] h_PassCount, h_FailCount;
    logic [2:0] h_State;

    chip_test_controller #(.TIMEOUT_CYCLES(4096), .HOLD_CYCLES(0), .CNT_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Done_i(Done_i), .RSLT_i(RSLT_i),
        .Run_o(Run_o), .DISP_RSLT_o(DISP_RSLT_o), .Busy(Busy), .Pass_LED(Pass_LED),
        .Fail_LED(Fail_LED), .Timeout_LED(Timeout_LED), .PassCount(PassCount),
        .FailCount(FailCount), .State_o(State_o)
    );

    chip_test_controller #(.TIMEOUT_CYCLES(4096), .HOLD_CYCLES(10), .CNT_W(8)) dut_h (
        .Clk(Clk), .Reset(Reset), .Start(h_Start), .Ack(h_Ack), .Done_i(h_Done), .RSLT_i(h_RSLT),
        .Run_o(h_Run), .DISP_RSLT_o(h_DISP), .Busy(h_Busy), .Pass_LED(h_Pass),
        .Fail_LED(h_Fail), .Timeout_LED(h_Tmo), .PassCount(h_PassCount),
        .FailCount(h_FailCount), .State_o(h_State)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int passes = 0;
    int run_pulses = 0, disp_pulses = 0, h_disp_pulses = 0, protocol_errs = 0;
    logic run_q = 1'b0, disp_q = 1'b0;

    // Pulse bookkeeping: Run/DISP never together, never two cycles in a row.
    always @(negedge Clk) begin
        if (Run_o) run_pulses <= run_pulses + 1;
        if (DISP_RSLT_o) disp_pulses <= disp_pulses + 1;
        if (h_DISP) h_disp_pulses <= h_disp_pulses + 1;
        if ((Run_o && DISP_RSLT_o) || (Run_o && run_q) || (DISP_RSLT_o && disp_q))
            protocol_errs <= protocol_errs + 1;
        run_q  <= Run_o;
        disp_q <= DISP_RSLT_o;
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wait_state(input int st, input int budget, input string nm);
        int n;
        n = 0;
        while (int'(State_o) != st && n < budget) begin
            tick();
            n++;
        end
        check(nm, int'(State_o), st);
    endtask

    // From IDLE: press Start, check Run_o lands in the 2nd cycle for one cycle.
    // Leaves us in the first WAIT_DONE cycle (watchdog 0).
    task automatic start_run(input string nm);
        check({nm, " idle"}, int'(State_o), S_IDLE);
        Start = 1'b1;
        tick();
        check({nm, " run latency"}, int'(Run_o), 1);
        tick();
        check({nm, " run width"}, int'(Run_o), 0);
        check({nm, " wait state"}, int'(State_o), S_WAIT);
        Start = 1'b0;
    endtask

    // Checker model: Done for two cycles, RSLT valid from the second one.
    task automatic checker_done(input bit rslt, input int delay);
        RSLT_i = ~rslt;
        tick(delay);
        Done_i = 1'b1;
        tick();
        RSLT_i = rslt;
        tick();
        Done_i = 1'b0;
    endtask

    task automatic ack_release(input string nm);
        check({nm, " show"}, int'(State_o), S_SHOW);
        Ack = 1'b1;
        tick();
        check({nm, " disp latency"}, int'(DISP_RSLT_o), 1);
        tick();
        check({nm, " disp width"}, int'(DISP_RSLT_o), 0);
        check({nm, " back idle"}, int'(State_o), S_IDLE);
        Ack = 1'b0;
    endtask

    typedef struct {
        bit rslt;
        int delay;
        bit pass_led;
        bit fail_led;
        int pc;
        int fc;
    } run_vec_t;

    run_vec_t tbl[4];

    initial begin
        int n, r0, d0;

        tbl[0] = '{rslt: 1'b1, delay: 2060, pass_led: 1'b1, fail_led: 1'b0, pc: 1, fc: 0};
        tbl[1] = '{rslt: 1'b0, delay: 2060, pass_led: 1'b0, fail_led: 1'b1, pc: 1, fc: 1};
        tbl[2] = '{rslt: 1'b1, delay: 5,    pass_led: 1'b1, fail_led: 1'b0, pc: 2, fc: 1};
        tbl[3] = '{rslt: 1'b0, delay: 0,    pass_led: 0,    fail_led: 1'b1, pc: 2, fc: 2};

        tick(3);
        check("reset state", int'(State_o), S_IDLE);
        check("reset busy", int'(Busy), 0);
        check("reset leds", int'({Pass_LED, Fail_LED, Timeout_LED}), 0);
        check("reset counts", int'({PassCount, FailCount}), 0);
        Reset = 1'b0;
        tick(2);

        // Normal runs from the table.
        for (int i = 0; i < 4; i++) begin
            string nm;
            nm = $sformatf("run%0d", i);
            start_run(nm);
            checker_done(tbl[i].rslt, tbl[i].delay);
            wait_state(S_SHOW, 10, {nm, " reach show"});
            check({nm, " pass_led"}, int'(Pass_LED), int'(tbl[i].pass_led));
            check({nm, " fail_led"}, int'(Fail_LED), int'(tbl[i].fail_led));
            check({nm, " timeout_led"}, int'(Timeout_LED), 0);
            check({nm, " pass_count"}, int'(PassCount), tbl[i].pc);
            check({nm, " fail_count"}, int'(FailCount), tbl[i].fc);
            ack_release(nm);
            check({nm, " led held idle"}, int'(Fail_LED), int'(tbl[i].fail_led));
        end

        // Checker never finishes: 4096 WAIT_DONE cycles then TIMEOUT.
        start_run("tmo");
        n = 0;
        while (int'(State_o) == S_WAIT && n < 5000) begin
            tick();
            n++;
        end
        check("tmo wait cycles", n, 4096);
        check("tmo state", int'(State_o), S_TMO);
        tick();
        check("tmo timeout_led", int'(Timeout_LED), 1);
        check("tmo fail_led", int'(Fail_LED), 1);
        check("tmo pass_led", int'(Pass_LED), 0);
        check("tmo fail_count", int'(FailCount), 3);
        check("tmo pass_count", int'(PassCount), 2);
        ack_release("tmo");
        check("tmo led sticky", int'(Timeout_LED), 1);

        // Done qualifying in the last watchdog cycle beats the timeout.
        start_run("late");
        check("late timeout cleared", int'(Timeout_LED), 0);
        tick(4094);
        Done_i = 1'b1;
        RSLT_i = 1'b1;
        tick(2);
        check("late capture", int'(State_o), S_CAPT);
        Done_i = 1'b0;
        tick();
        check("late pass_led", int'(Pass_LED), 1);
        check("late timeout_led", int'(Timeout_LED), 0);
        check("late pass_count", int'(PassCount), 3);
        ack_release("late");

        // Single-cycle Done glitches, plus Start presses while busy.
        r0 = run_pulses;
        start_run("glitch");
        RSLT_i = 1'b0;
        tick(3);
        Done_i = 1'b1; tick();
        Done_i = 1'b0; Start = 1'b1; tick();
        Done_i = 1'b1; tick();
        Done_i = 1'b0; Start = 1'b0; tick();
        Done_i = 1'b1; tick();
        Done_i = 1'b0; tick(2);
        check("glitch ignored", int'(State_o), S_WAIT);
        Done_i = 1'b1;
        tick();
        RSLT_i = 1'b1;
        tick();
        check("glitch capture", int'(State_o), S_CAPT);
        Done_i = 1'b0;
        tick();
        check("glitch pass_led", int'(Pass_LED), 1);
        check("glitch pass_count", int'(PassCount), 4);
        Start = 1'b1;
        tick(3);
        check("start in show ignored", int'(State_o), S_SHOW);
        Start = 1'b0;
        ack_release("glitch");
        tick(2);
        check("glitch single run", run_pulses - r0, 1);

        // Auto-release after 10 SHOW cycles.
        h_Start = 1'b1; tick(); h_Start = 1'b0; tick();
        h_Done = 1'b1; h_RSLT = 1'b1; tick(2); h_Done = 1'b0;
        n = 0;
        while (int'(h_State) != S_SHOW && n < 10) begin tick(); n++; end
        check("hold show", int'(h_State), S_SHOW);
        n = 0;
        while (!h_DISP && n < 30) begin tick(); n++; end
        check("hold expiry latency", n, 10);
        tick();
        check("hold idle", int'(h_State), S_IDLE);

        // Ack in the expiry cycle: one release only.
        h_Start = 1'b1; tick(); h_Start = 1'b0; tick();
        h_Done = 1'b1; tick(2); h_Done = 1'b0;
        n = 0;
        while (int'(h_State) != S_SHOW && n < 10) begin tick(); n++; end
        check("hold2 show", int'(h_State), S_SHOW);
        d0 = h_disp_pulses;
        tick(9);
        h_Ack = 1'b1;
        tick();
        check("hold2 disp", int'(h_DISP), 1);
        tick(4);
        h_Ack = 1'b0;
        tick(2);
        check("hold2 single disp", h_disp_pulses - d0, 1);
        check("hold2 idle", int'(h_State), S_IDLE);
        check("hold pass_count", int'(h_PassCount), 2);

        // Reset clears tallies; then saturate the pass tally.
        Reset = 1'b1;
        tick(2);
        check("rst2 pass_count", int'(PassCount), 0);
        check("rst2 fail_count", int'(FailCount), 0);
        Reset = 1'b0;
        tick();
        for (int i = 0; i < 300; i++) begin
            Start = 1'b1; tick(); Start = 1'b0; tick();
            Done_i = 1'b1; RSLT_i = 1'b1; tick(2); Done_i = 1'b0;
            wait_state(S_SHOW, 5, "sat show");
            if (i == 254) check("sat at 255 runs", int'(PassCount), 255);
            Ack = 1'b1; tick(); Ack = 1'b0; tick();
        end
        check("sat pass_count", int'(PassCount), 255);
        check("sat fail_count", int'(FailCount), 0);

        // Reset mid-test with Start held through it.
        Start = 1'b1;
        tick(2);
        check("midrst wait", int'(State_o), S_WAIT);
        Reset = 1'b1;
        tick(2);
        check("midrst idle", int'(State_o), S_IDLE);
        check("midrst counts", int'({PassCount, FailCount}), 0);
        check("midrst leds", int'({Pass_LED, Fail_LED, Timeout_LED}), 0);
        Reset = 1'b0;
        tick();
        r0 = run_pulses;
        tick(20);
        check("midrst no run", run_pulses - r0, 0);
        check("midrst still idle", int'(State_o), S_IDLE);
        Start = 1'b0;
        tick(2);

        check("pulse protocol errors", protocol_errs, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
